// File: rtl/ialu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ialu_pkg
//  Description : Shared definitions for the integer ALU completion path:
//                unit indices, encoded unit codes, the fused branch+adder
//                enable pattern, the completion FSM state type and a small
//                latency saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ialu_pkg;

    // Position of each functional unit on the one-hot enable/done buses.
    localparam int IALU_ADD    = 0;
    localparam int IALU_MUL    = 1;
    localparam int IALU_DIV    = 2;
    localparam int IALU_SET    = 3;
    localparam int IALU_LOGIC  = 4;
    localparam int IALU_SHIFT  = 5;
    localparam int IALU_BRANCH = 6;

    // Encoded unit identifiers reported on writeback.
    localparam logic [2:0] CODE_ADD    = 3'b000;
    localparam logic [2:0] CODE_MUL    = 3'b001;
    localparam logic [2:0] CODE_DIV    = 3'b010;
    localparam logic [2:0] CODE_SET    = 3'b011;
    localparam logic [2:0] CODE_LOGIC  = 3'b100;
    localparam logic [2:0] CODE_SHIFT  = 3'b101;
    localparam logic [2:0] CODE_BRANCH = 3'b110;

    // A branch issues together with the address adder; the adder produces
    // the completion strobe and the result for that fused operation.
    localparam logic [7:0] BRANCH_ONEHOT = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Clamp a latency value to the 8-bit writeback field.
    function automatic logic [7:0] sat_lat8(input logic [31:0] value);
        return (value > 32'd255) ? 8'hFF : value[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ialu_onehot_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ialu_onehot_encoder
//  Description : Combinational re-encoder for the one-hot unit enables.
//                A single set bit encodes to its index; the fused
//                branch+adder pattern encodes to the branch code but names
//                the adder as the unit that completes the operation.
//                Every other pattern (including all-zero) is illegal.
//  Ports       : issue_en   in  UNITS       one-hot unit enables
//                code       out DECODER_IN  encoded unit identifier
//                src_index  out DECODER_IN  unit whose done/result is used
//                legal      out 1           pattern is accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module ialu_onehot_encoder
    import ialu_pkg::*;
#(
    parameter int DECODER_IN = 3,
    parameter int UNITS      = 2**DECODER_IN
) (
    input  logic [UNITS-1:0]      issue_en,
    output logic [DECODER_IN-1:0] code,
    output logic [DECODER_IN-1:0] src_index,
    output logic                  legal
);

    logic [DECODER_IN:0]   ones;
    logic [DECODER_IN-1:0] hot_idx;

    always_comb begin
        ones      = '0;
        hot_idx   = '0;
        code      = '0;
        src_index = '0;
        legal     = 1'b0;

        // Population count plus index of the (last) set bit; the index is
        // only meaningful when exactly one bit is set.
        for (int i = 0; i < UNITS; i++) begin
            if (issue_en[i]) begin
                ones    = ones + (DECODER_IN+1)'(1);
                hot_idx = DECODER_IN'(i);
            end
        end

        if (issue_en == UNITS'(BRANCH_ONEHOT)) begin
            code      = DECODER_IN'(CODE_BRANCH);
            src_index = DECODER_IN'(IALU_ADD);
            legal     = 1'b1;
        end else begin
            code      = hot_idx;
            src_index = hot_idx;
            legal     = (ones == (DECODER_IN+1)'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/ialu_result_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ialu_result_encoder
//  Description : Completion side of the integer ALU. Accepts one one-hot
//                issue at a time, waits for the selected unit's done strobe
//                (with a timeout for multi-cycle units), captures its
//                result, re-encodes the unit id and presents the result to
//                writeback over a valid/ready handshake.
//  Ports       : CLK          in  1           clock, rising edge
//                rst          in  1           synchronous active-high reset
//                issue_valid  in  1           issue_en valid this cycle
//                issue_en     in  UNITS       one-hot unit enables
//                issue_ready  out 1           idle, can accept an issue
//                unit_done    in  UNITS       per-unit completion strobes
//                unit_result  in  UNITS*XLEN  per-unit results
//                wb_valid     out 1           writeback result available
//                wb_ready     in  1           writeback accepts
//                wb_data      out XLEN        captured result
//                wb_code      out DECODER_IN  encoded unit id
//                wb_lat       out 8           issue-to-done cycles, sat 255
//                err_illegal  out 1           pulse: illegal issue pattern
//                err_timeout  out 1           pulse: unit never completed
//  Revision    : 1.0 - initial release
// ============================================================================
module ialu_result_encoder
    import ialu_pkg::*;
#(
    parameter int DECODER_IN = 3,
    parameter int UNITS      = 2**DECODER_IN,
    parameter int XLEN       = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [UNITS-1:0]      issue_en,
    output logic                  issue_ready,
    input  logic [UNITS-1:0]      unit_done,
    input  logic [UNITS*XLEN-1:0] unit_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [XLEN-1:0]       wb_data,
    output logic [DECODER_IN-1:0] wb_code,
    output logic [7:0]            wb_lat,
    output logic                  err_illegal,
    output logic                  err_timeout
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Issue pattern decode
    // ------------------------------------------------------------------
    logic [DECODER_IN-1:0] enc_code;
    logic [DECODER_IN-1:0] enc_src;
    logic                  enc_legal;

    ialu_onehot_encoder #(
        .DECODER_IN (DECODER_IN),
        .UNITS      (UNITS)
    ) u_encoder (
        .issue_en   (issue_en),
        .code       (enc_code),
        .src_index  (enc_src),
        .legal      (enc_legal)
    );

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e                state_q,       state_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [DECODER_IN-1:0] code_q,        code_d;
    logic [DECODER_IN-1:0] idx_q,         idx_d;
    logic [XLEN-1:0]       wb_data_q,     wb_data_d;
    logic [DECODER_IN-1:0] wb_code_q,     wb_code_d;
    logic [7:0]            wb_lat_q,      wb_lat_d;
    logic                  wb_valid_q,    wb_valid_d;
    logic                  issue_ready_q, issue_ready_d;
    logic                  err_illegal_q, err_illegal_d;
    logic                  err_timeout_q, err_timeout_d;

    // ------------------------------------------------------------------
    // Expected-unit selection. In IDLE the unit comes straight from the
    // decoder so a same-cycle done can be captured; afterwards it comes
    // from the latched index.
    // ------------------------------------------------------------------
    logic [DECODER_IN-1:0] sel_idx;
    logic                  sel_done;
    logic [XLEN-1:0]       sel_result;
    logic                  accept;

    always_comb begin
        sel_idx    = (state_q == ST_IDLE) ? enc_src : idx_q;
        sel_done   = unit_done[sel_idx];
        sel_result = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (sel_idx == DECODER_IN'(i)) begin
                sel_result = unit_result[i*XLEN +: XLEN];
            end
        end
    end

    assign accept = issue_valid & issue_ready_q;

    // ------------------------------------------------------------------
    // Next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        code_d        = code_q;
        idx_d         = idx_q;
        wb_data_d     = wb_data_q;
        wb_code_d     = wb_code_q;
        wb_lat_d      = wb_lat_q;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!enc_legal) begin
                        err_illegal_d = 1'b1;
                    end else begin
                        code_d = enc_code;
                        idx_d  = enc_src;
                        cnt_d  = '0;
                        if (sel_done) begin
                            wb_data_d = sel_result;
                            wb_code_d = enc_code;
                            wb_lat_d  = 8'd0;
                            state_d   = ST_HOLD;
                        end else begin
                            state_d   = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                // Done is checked before the timeout so a completion in the
                // final counted cycle still writes back.
                if (sel_done) begin
                    wb_data_d = sel_result;
                    wb_code_d = code_q;
                    wb_lat_d  = sat_lat8(32'(cnt_q) + 32'd1);
                    state_d   = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered decodes of the next state so they
        // line up with the state register.
        wb_valid_d    = (state_d == ST_HOLD);
        issue_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            code_q        <= '0;
            idx_q         <= '0;
            wb_data_q     <= '0;
            wb_code_q     <= '0;
            wb_lat_q      <= '0;
            wb_valid_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            idx_q         <= idx_d;
            wb_data_q     <= wb_data_d;
            wb_code_q     <= wb_code_d;
            wb_lat_q      <= wb_lat_d;
            wb_valid_q    <= wb_valid_d;
            issue_ready_q <= issue_ready_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_code     = wb_code_q;
    assign wb_lat      = wb_lat_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire
